// File: rtl/systolic_mm_if.sv
// Handshake bus for systolic_mm: the input beat stream and the result stream.
interface systolic_mm_if #(
    parameter int unsigned DW  = 16,
    parameter int unsigned SZW = 2,
    parameter int unsigned OW  = 34
);
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  matrix;
    logic [SZW-1:0] matrix_size;
    logic           out_valid;
    logic           out_ready;
    logic [OW-1:0]  out_value;

    modport master (output in_valid, matrix, matrix_size, out_ready,
                    input  in_ready, out_valid, out_value);
    modport slave  (input  in_valid, matrix, matrix_size, out_ready,
                    output in_ready, out_valid, out_value);
endinterface

// File: rtl/systolic_mm.sv
// Weight-stationary systolic matrix multiplier: C = X * W for n x n matrices,
// n <= MAX_N. W then X are streamed in row-major; C is streamed out row-major.
module systolic_mm #(
    parameter int unsigned MAX_N  = 4,
    parameter int unsigned DW     = 16,
    parameter int unsigned SIGNED = 0
) (
    input logic          clk,
    input logic          rst_n,
    systolic_mm_if.slave bus
);
    localparam int unsigned SZW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int unsigned OW  = 2*DW + SZW;
    localparam int unsigned CW  = $clog2(4*MAX_N + 4);
    localparam int unsigned LAT = 2*MAX_N + 2;
    localparam int          CAP0 = int'(MAX_N);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, COMPUTE, OUTPUT} state_t;

    state_t         state_q, state_d;
    logic [SZW-1:0] n_m1, row_q, col_q, row_nx, col_nx;
    logic [CW-1:0]  cyc_q;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [OW-1:0]  out_value_q, out_value_d;
    logic           accept_in, accept_out, last_pos, active;

    logic [DW-1:0]  w_store [MAX_N][MAX_N];
    logic [DW-1:0]  x_store [MAX_N][MAX_N];
    logic [OW-1:0]  res_buf [MAX_N][MAX_N];
    logic [DW-1:0]  x_pe    [MAX_N][MAX_N];
    logic [OW-1:0]  ps_pe   [MAX_N][MAX_N];
    logic [DW-1:0]  x_inj   [MAX_N];

    // Extend an element to the result width so the product is exact in OW bits.
    function automatic logic [OW-1:0] ext(input logic [DW-1:0] v);
        if (SIGNED != 0) return {{(OW-DW){v[DW-1]}}, v};
        return {{(OW-DW){1'b0}}, v};
    endfunction

    assign accept_in  = bus.in_valid && in_ready_q;
    assign accept_out = out_valid_q && bus.out_ready;
    assign last_pos   = (row_q == n_m1) && (col_q == n_m1);
    assign active     = (state_q == COMPUTE) || (state_q == OUTPUT);
    assign col_nx     = (col_q == n_m1) ? '0 : col_q + SZW'(1);
    assign row_nx     = (col_q == n_m1) ? row_q + SZW'(1) : row_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
        end
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        case (state_q)
            IDLE: begin
                if (accept_in) state_d = (bus.matrix_size == '0) ? LOAD_X : LOAD_W;
            end
            LOAD_W: begin
                if (accept_in && last_pos) state_d = LOAD_X;
            end
            LOAD_X: begin
                if (accept_in && last_pos) begin
                    state_d    = COMPUTE;
                    in_ready_d = 1'b0;
                end
            end
            COMPUTE: begin
                // Fixed latency: C[0][0] is always captured well before this point.
                if (cyc_q == CW'(LAT - 1)) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_value_d = res_buf[0][0];
                end
            end
            OUTPUT: begin
                if (accept_out) begin
                    if (last_pos) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_value_d = '0;
                        in_ready_d  = 1'b1;
                    end else begin
                        out_value_d = res_buf[row_nx][col_nx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat/element position counters, run-time counter and operand stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_m1  <= '0;
            row_q <= '0;
            col_q <= '0;
            cyc_q <= '0;
            for (int r = 0; r < int'(MAX_N); r++) begin
                for (int c = 0; c < int'(MAX_N); c++) begin
                    w_store[r][c] <= '0;
                    x_store[r][c] <= '0;
                end
            end
        end else begin
            cyc_q <= active ? ((cyc_q == '1) ? cyc_q : cyc_q + CW'(1)) : '0;
            case (state_q)
                IDLE: begin
                    if (accept_in) begin
                        n_m1          <= bus.matrix_size;
                        w_store[0][0] <= bus.matrix;
                        row_q         <= '0;
                        col_q         <= (bus.matrix_size == '0) ? '0 : SZW'(1);
                    end
                end
                LOAD_W: begin
                    if (accept_in) begin
                        w_store[row_q][col_q] <= bus.matrix;
                        row_q <= last_pos ? '0 : row_nx;
                        col_q <= last_pos ? '0 : col_nx;
                    end
                end
                LOAD_X: begin
                    if (accept_in) begin
                        x_store[row_q][col_q] <= bus.matrix;
                        row_q <= last_pos ? '0 : row_nx;
                        col_q <= last_pos ? '0 : col_nx;
                    end
                end
                OUTPUT: begin
                    if (accept_out) begin
                        row_q <= last_pos ? '0 : row_nx;
                        col_q <= last_pos ? '0 : col_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Skewed X injection: row k of the array receives X[i][k] at run cycle i+k.
    always_comb begin
        for (int k = 0; k < int'(MAX_N); k++) begin
            x_inj[k] = '0;
            for (int i = 0; i < int'(MAX_N); i++) begin
                if (active && int'(cyc_q) == i + k && i <= int'(n_m1) && k <= int'(n_m1))
                    x_inj[k] = x_store[i][k];
            end
        end
    end

    // PE grid: X moves right, partial sums move down, weights stay put.
    for (genvar k = 0; k < MAX_N; k++) begin : g_row
        for (genvar j = 0; j < MAX_N; j++) begin : g_col
            logic [DW-1:0] x_left, wt, x_r;
            logic [OW-1:0] ps_above, ps_r;

            if (j == 0) begin : g_x_edge
                assign x_left = x_inj[k];
            end else begin : g_x_pass
                assign x_left = x_pe[k][j-1];
            end

            if (k == 0) begin : g_ps_edge
                assign ps_above = '0;
            end else begin : g_ps_pass
                assign ps_above = ps_pe[k-1][j];
            end

            // PEs outside the active n x n corner hold a zero weight.
            assign wt = (SZW'(k) <= n_m1 && SZW'(j) <= n_m1) ? w_store[k][j] : '0;

            // Multiply-accumulate and forward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_r  <= '0;
                    ps_r <= '0;
                end else begin
                    x_r  <= x_left;
                    ps_r <= ps_above + ext(x_left) * ext(wt);
                end
            end

            assign x_pe[k][j]  = x_r;
            assign ps_pe[k][j] = ps_r;
        end
    end

    // Capture C[i][j] from the bottom row when it emerges at run cycle i+j+MAX_N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_N); i++) begin
                for (int j = 0; j < int'(MAX_N); j++) res_buf[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(MAX_N); i++) begin
                for (int j = 0; j < int'(MAX_N); j++) begin
                    if (active && int'(cyc_q) == i + j + CAP0 &&
                        i <= int'(n_m1) && j <= int'(n_m1))
                        res_buf[i][j] <= ps_pe[MAX_N-1][j];
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_mm.sv
// Bench for systolic_mm: an unsigned and a signed instance run the same jobs in
// lockstep, each checked against a plain-arithmetic matrix product.
module tb_systolic_mm;
    localparam int unsigned MAX_N = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned SZW   = 2;
    localparam int unsigned OW    = 34;
    localparam int          LAT   = 2*MAX_N + 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    systolic_mm_if #(.DW(DW), .SZW(SZW), .OW(OW)) bus_u ();
    systolic_mm_if #(.DW(DW), .SZW(SZW), .OW(OW)) bus_s ();

    systolic_mm #(.MAX_N(MAX_N), .DW(DW), .SIGNED(0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(bus_u));
    systolic_mm #(.MAX_N(MAX_N), .DW(DW), .SIGNED(1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

    always #5 clk = ~clk;

    logic [DW-1:0] wm [MAX_N][MAX_N];
    logic [DW-1:0] xm [MAX_N][MAX_N];
    logic [OW-1:0] exp_u [$];
    logic [OW-1:0] exp_s [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [SZW-1:0] sz);
        bus_u.in_valid = v; bus_u.matrix = d; bus_u.matrix_size = sz;
        bus_s.in_valid = v; bus_s.matrix = d; bus_s.matrix_size = sz;
    endtask

    task automatic set_ready(input logic r);
        bus_u.out_ready = r;
        bus_s.out_ready = r;
    endtask

    function automatic longint sval(input logic [DW-1:0] v, input bit s);
        return s ? longint'($signed(v)) : longint'(v);
    endfunction

    // Reference product C = X * W, row-major, for both arithmetic modes.
    task automatic build_exp(input int n);
        longint au, as_;
        exp_u.delete();
        exp_s.delete();
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                au = 0; as_ = 0;
                for (int k = 0; k < n; k++) begin
                    au  += sval(xm[i][k], 1'b0) * sval(wm[k][j], 1'b0);
                    as_ += sval(xm[i][k], 1'b1) * sval(wm[k][j], 1'b1);
                end
                exp_u.push_back(OW'(au));
                exp_s.push_back(OW'(as_));
            end
        end
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < int'(MAX_N); r++) begin
            for (int c = 0; c < int'(MAX_N); c++) begin
                wm[r][c] = (mode == 1) ? 16'hFFFF : (mode == 2) ? DW'($urandom) : '0;
                xm[r][c] = (mode == 1) ? 16'hFFFF : (mode == 2) ? DW'($urandom) : '0;
            end
        end
    endtask

    // Stream `count` beats (W then X); matrix_size is garbage on all but the first.
    task automatic load_beats(input int n, input int count, input bit gaps);
        logic [DW-1:0] d;
        int e, g;
        for (int b = 0; b < count; b++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    drive(1'b0, DW'($urandom), SZW'($urandom));
                end
            end
            @(negedge clk);
            e = (b < n*n) ? b : b - n*n;
            d = (b < n*n) ? wm[e/n][e%n] : xm[e/n][e%n];
            drive(1'b1, d, (b == 0) ? SZW'(n-1) : ~SZW'(n-1));
            chk("in_ready_load", bus_u.in_ready && bus_s.in_ready, 1);
        end
    endtask

    // mode 0: out_ready held high; 1: 5-cycle stall on element 1 plus in_valid noise; 2: random ready.
    task automatic run_job(input int n, input bit gaps, input int mode);
        int   idx, got, stall, bound;
        logic r;
        build_exp(n);
        load_beats(n, 2*n*n, gaps);
        @(negedge clk);
        drive(1'b0, '0, '0);
        set_ready(1'b0);
        idx = 0;
        chk("in_ready_busy", bus_u.in_ready, 0);
        while (bus_u.out_valid !== 1'b1 && idx < 100) begin
            @(negedge clk);
            idx++;
            if (mode == 1) drive(1'($urandom_range(0, 1)), DW'($urandom), SZW'($urandom));
        end
        chk("first_out_latency", idx, LAT);
        chk("first_out_valid_s", bus_s.out_valid, 1);
        got = 0; stall = 0; bound = 0;
        while (got < n*n && bound < 500) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = !(got == 1 && stall < 5);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (got == 1 && !r) stall++;
            set_ready(r);
            if (mode == 1) drive(1'($urandom_range(0, 1)), DW'($urandom), SZW'($urandom));
            chk("out_valid_u", bus_u.out_valid, 1);
            chk("out_valid_s", bus_s.out_valid, 1);
            chk("in_ready_output", bus_u.in_ready || bus_s.in_ready, 0);
            chk($sformatf("out_u[%0d]", got), bus_u.out_value, exp_u[got]);
            chk($sformatf("out_s[%0d]", got), bus_s.out_value, exp_s[got]);
            if (r) got++;
            @(negedge clk);
            bound++;
        end
        drive(1'b0, '0, '0);
        set_ready(1'b0);
        chk("done_valid_u", bus_u.out_valid, 0);
        chk("done_valid_s", bus_s.out_valid, 0);
        chk("done_value_u", bus_u.out_value, 0);
        chk("done_value_s", bus_s.out_value, 0);
        chk("done_in_ready", bus_u.in_ready && bus_s.in_ready, 1);
    endtask

    task automatic set_2x2();
        fill(0);
        wm[0][0] = 1; wm[0][1] = 2; wm[1][0] = 3; wm[1][1] = 4;
        xm[0][0] = 5; xm[0][1] = 6; xm[1][0] = 7; xm[1][1] = 8;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        drive(1'b0, '0, '0);
        set_ready(1'b0);
        repeat (3) @(negedge clk);
        chk("reset_out_valid", bus_u.out_valid || bus_s.out_valid, 0);
        chk("reset_out_value_u", bus_u.out_value, 0);
        chk("reset_out_value_s", bus_s.out_value, 0);
        chk("reset_in_ready", bus_u.in_ready && bus_s.in_ready, 1);
        rst_n = 1'b1;

        // 2x2 reference job with a continuously ready consumer.
        set_2x2();
        run_job(2, 1'b0, 0);

        // Full-size job with all-ones operands.
        fill(1);
        run_job(4, 1'b0, 0);

        // Scalar job with input gaps and a bogus matrix_size on the X beat.
        fill(0);
        wm[0][0] = 7; xm[0][0] = 9;
        run_job(1, 1'b1, 0);

        // 2x2 job with a 5-cycle stall on the second element and in_valid noise.
        set_2x2();
        run_job(2, 1'b0, 1);

        // Sign handling: -1 * 2.
        fill(0);
        wm[0][0] = 16'hFFFF; xm[0][0] = 16'h0002;
        run_job(1, 1'b0, 0);

        // Reset in the middle of the X stream, then a fresh 2x2 job.
        fill(2);
        load_beats(4, 16 + 5, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", bus_u.out_valid || bus_s.out_valid, 0);
        chk("midreset_in_ready", bus_u.in_ready && bus_s.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        set_2x2();
        run_job(2, 1'b0, 0);

        // Randomized jobs.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, MAX_N);
            fill(2);
            run_job(n, 1'b1, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
